// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit.
// Also holds the funct3-to-ALU-operation helpers used by the instruction decoder.
package multicycle_control_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SRL  = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  localparam logic [2:0] RESULT_ALU    = 3'd0;
  localparam logic [2:0] RESULT_IMM    = 3'd1;
  localparam logic [2:0] RESULT_PC_IMM = 3'd2;
  localparam logic [2:0] RESULT_PC4    = 3'd3;
  localparam logic [2:0] RESULT_MEM    = 3'd4;
  localparam logic [2:0] RESULT_NONE   = 3'd5;

  localparam logic [1:0] PC_SRC_JALR   = 2'd0;
  localparam logic [1:0] PC_SRC_JAL    = 2'd1;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd2;
  localparam logic [1:0] PC_SRC_PC4    = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, INVALID_TYPE
  } instruction_t;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
  } alu_op_t;

  // alt selects SUB/SRA; callers decide when instr[30] is meaningful.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      FUNCT3_ADD:  arith_op = alt ? ALU_SUB : ALU_ADD;
      FUNCT3_SLL:  arith_op = ALU_SLL;
      FUNCT3_SLT:  arith_op = ALU_SLT;
      FUNCT3_SLTU: arith_op = ALU_SLTU;
      FUNCT3_XOR:  arith_op = ALU_XOR;
      FUNCT3_SRL:  arith_op = alt ? ALU_SRA : ALU_SRL;
      FUNCT3_OR:   arith_op = ALU_OR;
      default:     arith_op = ALU_AND;
    endcase
  endfunction

  function automatic alu_op_t branch_op(input logic [2:0] f3);
    case (f3)
      FUNCT3_BNE:  branch_op = ALU_BNE;
      FUNCT3_BLT:  branch_op = ALU_BLT;
      FUNCT3_BGE:  branch_op = ALU_BGE;
      FUNCT3_BLTU: branch_op = ALU_BLTU;
      FUNCT3_BGEU: branch_op = ALU_BGEU;
      default:     branch_op = ALU_BEQ;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Shared instruction/data memory handshake between the control unit and memory.
interface multicycle_control_if;
  logic mem_req;
  logic mem_wen;
  logic mem_ready;

  modport master (output mem_req, output mem_wen, input mem_ready);
  modport slave  (input mem_req, input mem_wen, output mem_ready);
endinterface

// File: rtl/multicycle_control_instr_decoder.sv
// Combinational RV32I field decoder: format, ALU operation, operand/result selects
// and illegal-encoding detection.
module multicycle_control_instr_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0]   op,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  output instruction_t instruction_type,
  output alu_op_t      alu_control,
  output logic         alu_src,
  output logic [2:0]   result_src,
  output logic         illegal
);

  always_comb begin
    instruction_type = INVALID_TYPE;
    alu_control      = ALU_ADD;
    alu_src          = 1'b0;
    result_src       = RESULT_NONE;
    illegal          = 1'b0;
    case (op)
      OP_REG: begin
        instruction_type = R_TYPE;
        result_src       = RESULT_ALU;
        alu_control      = arith_op(funct3, funct7_5);
        illegal          = funct7_5 && (funct3 != FUNCT3_ADD) && (funct3 != FUNCT3_SRL);
      end
      OP_IMM: begin
        // instr[30] is an immediate bit except for shift-right
        instruction_type = I_TYPE;
        alu_src          = 1'b1;
        result_src       = RESULT_ALU;
        alu_control      = arith_op(funct3, funct7_5 && (funct3 == FUNCT3_SRL));
      end
      OP_LOAD: begin
        instruction_type = I_TYPE;
        alu_src          = 1'b1;
        result_src       = RESULT_MEM;
        illegal          = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        instruction_type = S_TYPE;
        alu_src          = 1'b1;
        illegal          = funct3 > 3'b010;
      end
      OP_BRANCH: begin
        instruction_type = B_TYPE;
        alu_control      = branch_op(funct3);
        illegal          = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_LUI: begin
        instruction_type = U_TYPE;
        alu_src          = 1'b1;
        result_src       = RESULT_IMM;
      end
      OP_AUIPC: begin
        instruction_type = U_TYPE;
        alu_src          = 1'b1;
        result_src       = RESULT_PC_IMM;
      end
      OP_JAL: begin
        instruction_type = J_TYPE;
        alu_src          = 1'b1;
        result_src       = RESULT_PC4;
      end
      OP_JALR: begin
        instruction_type = I_TYPE;
        alu_src          = 1'b1;
        result_src       = RESULT_PC4;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      instruction_type = INVALID_TYPE;
      result_src       = RESULT_NONE;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/writeback sequencing,
// memory handshake with timeout trap, and illegal-instruction handling.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit ILLEGAL_TRAP = 1'b1,
  parameter int ALU_CTRL_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  alu_zero,
  multicycle_control_if.master  mem,
  output logic                  ir_wen,
  output logic                  pc_wen,
  output logic [1:0]            pc_src,
  output logic                  reg_wen,
  output logic [2:0]            result_src,
  output logic                  alu_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output instruction_t          instruction_type,
  output logic                  trap,
  output logic [2:0]            state
);

  localparam int CNT_W      = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int CNT_LAST_I = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req_c, mem_wen_c;
  alu_op_t          dec_alu;
  logic             dec_illegal;

  multicycle_control_instr_decoder u_dec (
    .op               (op),
    .funct3           (funct3),
    .funct7_5         (funct7_5),
    .instruction_type (instruction_type),
    .alu_control      (dec_alu),
    .alu_src          (alu_src),
    .result_src       (result_src),
    .illegal          (dec_illegal)
  );

  assign alu_control = ALU_CTRL_W'(dec_alu);
  assign mem.mem_req = mem_req_c;
  assign mem.mem_wen = mem_wen_c;
  assign state       = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_req_c = 1'b0;
    mem_wen_c = 1'b0;
    ir_wen    = 1'b0;
    pc_wen    = 1'b0;
    pc_src    = PC_SRC_PC4;
    reg_wen   = 1'b0;
    trap      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_wen  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_illegal) state_d = ILLEGAL_TRAP ? S_TRAP : S_WRITEBACK;
        else             state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (op == OP_BRANCH) begin
          pc_wen  = 1'b1;
          pc_src  = alu_zero ? PC_SRC_BRANCH : PC_SRC_PC4;
          state_d = S_FETCH;
        end else if ((op == OP_LOAD) || (op == OP_STORE)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_wen_c = (op == OP_STORE);
        if (mem.mem_ready) begin
          if (op == OP_STORE) begin
            pc_wen  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        // An illegal op only reaches here as a NOP: advance PC, write nothing
        pc_wen  = 1'b1;
        reg_wen = !dec_illegal;
        if (!dec_illegal && (op == OP_JALR))     pc_src = PC_SRC_JALR;
        else if (!dec_illegal && (op == OP_JAL)) pc_src = PC_SRC_JAL;
        state_d = S_FETCH;
      end
      S_TRAP:  trap = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // A ready in the last allowed wait cycle completes the request instead of trapping
    if ((MEM_TIMEOUT != 0) && mem_req_c && !mem.mem_ready && (cnt_q == CNT_LAST))
      state_d = S_TRAP;

    if ((state_d != state_q) || !mem_req_c || mem.mem_ready) cnt_d = '0;
    else if (cnt_q != CNT_MAX)                                cnt_d = cnt_q + 1'b1;

    if (rst) begin
      mem_req_c = 1'b0;
      mem_wen_c = 1'b0;
      ir_wen    = 1'b0;
      pc_wen    = 1'b0;
      pc_src    = PC_SRC_PC4;
      reg_wen   = 1'b0;
      trap      = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle successor to the single-cycle RV32I control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath register enables and talks to a shared instruction/data memory over a ready-based handshake. It adds illegal-instruction detection and a memory-timeout trap.

Parameters:
MEM_TIMEOUT, 16, cycles a memory request may wait for mem_ready before trapping; 0 disables the timeout.
ILLEGAL_TRAP, 1, 1 = illegal encodings enter TRAP; 0 = treated as NOP (PC+4, no writes).
ALU_CTRL_W, 4, width of alu_control.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
op  in  7  opcode from instruction register, valid from DECODE onward
funct3  in  3  from instruction register
funct7_5  in  1  instr[30]
alu_zero  in  1  branch-condition flag from ALU
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_wen  out  1  store request (qualifies mem_req)
ir_wen  out  1  latch fetched instruction and old PC
pc_wen  out  1  update PC
pc_src  out  2  0 JALR target, 1 JAL target, 2 branch target, 3 PC+4
reg_wen  out  1  register file write
result_src  out  3  0 ALU, 1 imm, 2 PC+imm, 3 PC+4, 4 mem data, 5 none
alu_src  out  1  0 rs2, 1 imm
alu_control  out  ALU_CTRL_W  ALU operation (alu_op_t)
instruction_type  out  instruction_t  decoded format
trap  out  1  sticky fault indicator
state  out  3  current state, for debug

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. While rst=1, all enables, mem_req and trap are 0. Next state is FETCH, the timeout counter clears, and pc_src defaults to 3.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP. The state register is registered; outputs are combinational from state, decoded fields and mem_ready.
- FETCH:
  - mem_req=1, mem_wen=0.
  - On mem_ready: ir_wen=1 for that cycle only, then go to DECODE.
- DECODE:
  - Takes one cycle with no enables asserted.
  - On an illegal encoding: go to TRAP, or to WRITEBACK as a NOP when ILLEGAL_TRAP=0.
  - Otherwise go to EXECUTE.
- Illegal encodings:
  - op not in {LUI, AUIPC, JAL, JALR, REG, IMM, LOAD, STORE, BRANCH}.
  - BRANCH with funct3 010 or 011.
  - LOAD with funct3 011, 110 or 111.
  - STORE with funct3 above 010.
  - REG with funct7_5=1 and funct3 not ADD/SRL.
- EXECUTE:
  - alu_src and alu_control are decoded exactly as in the single-cycle encoding; SRA/SUB are selected by funct7_5.
  - BRANCH: pc_wen=1, pc_src=2 if alu_zero else 3, then go to FETCH.
  - LOAD/STORE: go to MEM.
  - All other ops: go to WRITEBACK.
- MEM:
  - mem_req=1; mem_wen=1 for STORE.
  - Held until mem_ready.
  - STORE then does pc_wen=1, pc_src=3 in the mem_ready cycle and goes to FETCH.
  - LOAD goes to WRITEBACK.
- WRITEBACK:
  - reg_wen=1 and pc_wen=1 for one cycle, then go to FETCH.
  - result_src: 0 for REG/IMM, 1 for LUI, 2 for AUIPC, 3 for JAL/JALR, 4 for LOAD.
  - pc_src: 0 for JALR, 1 for JAL, 3 otherwise.
  - For a NOP: reg_wen=0 and result_src=5.
- TRAP:
  - All enables 0 and trap=1.
  - Exit only via rst.
- Timeout:
  - The counter increments each cycle that mem_req=1 and mem_ready=0, and clears on mem_ready or any state change.
  - When the counter reaches MEM_TIMEOUT (and MEM_TIMEOUT≠0), go to TRAP next cycle.
  - If mem_ready arrives in the same cycle, mem_ready wins and there is no trap.
  - The counter saturates; it is wide enough for MEM_TIMEOUT.
- Ignored inputs: mem_ready while mem_req=0 is ignored. op/funct inputs are ignored in FETCH.
- Latency with zero-wait memory (first cycle of FETCH to return to FETCH):
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Reset mid-operation: any state returns to FETCH on the cycle after rst. An outstanding memory request is dropped, so mem_req=0 during rst.

Decomposition:
- Shared package types additions:
  - state_t enum.
  - alu_op_t widened to ALU_CTRL_W, covering ALU ops plus branch compares.
  - RESULT_* and PC_SRC_* constants.
  - Existing OP_*/FUNCT3_* constants are reused.
- One combinational sub-module, instr_decoder. Inputs: op, funct3, funct7_5. Outputs: instruction_type, alu_control, alu_src, result_src, illegal.
- multicycle_control holds the FSM, the timeout counter and the enable gating.

Test Plan:
- ADD opcode 0110011, funct3 000, funct7_5=1, mem_ready=1 in FETCH → alu_control=ALU_SUB in EXECUTE; reg_wen=1, result_src=0, pc_src=3 in cycle 4; FETCH in cycle 5.
- BEQ (1100011/000) with alu_zero=1 → cycle 3 pc_wen=1, pc_src=2; repeat with alu_zero=0 → pc_src=3; no reg_wen in either case.
- LW (0000011/010) with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles with mem_wen=0; then WRITEBACK with reg_wen=1, result_src=4.
- SW (0100011/010) → mem_req=1, mem_wen=1 in MEM; pc_wen=1 on the mem_ready cycle; reg_wen never asserted.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → trap=1 after 4 wait cycles and stays high. Repeat with mem_ready arriving in the 4th cycle → no trap. Illegal op 0000000 → TRAP after DECODE.
- Assert rst for 1 cycle mid-MEM of a store → mem_req=mem_wen=0 during rst; FETCH with mem_req=1 on the next cycle; trap=0.
